pipeline_skid_reg: RTL

Parametrised pipeline stage register, the next generation of the fixed inter-stage registers (e.g. MEM/WB) in the pipelined processor. It adds a valid/ready handshake with a 2-entry skid buffer for full throughput under backpressure, and a synchronous flush for branch/hazard squash. Control fields are gated on bubbles so that RegWrite-type signals never assert for an invalid slot. It also has saturating stall and bubble counters for performance debug.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/sat_counter.sv | 29 ++
 rtl/pipeline_skid_reg.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared constants for the skid-buffered pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int DEF_W      = 32;
    localparam int DEF_CTRL_W = 4;
    localparam int DEF_CNT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_skid_reg
//  Description : Valid/ready pipeline register with 2-entry skid buffer,
//                synchronous flush and saturating stall/bubble counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_skid_reg
    import pipeline_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [W-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [W-1:0]      out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              r_main_valid;
    logic              r_skid_valid;
    logic [W-1:0]      r_main_data;
    logic [W-1:0]      r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_in_fire;
    logic w_out_fire;

    // in_ready depends only on a flop, so there is no in->out combinational path
    assign in_ready   = ~r_skid_valid;
    assign w_in_fire  = in_valid & ~r_skid_valid;
    assign w_out_fire = r_main_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_ctrl  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid) begin
            if (w_in_fire) begin
                r_main_valid <= 1'b1;
                r_main_data  <= in_data;
                r_main_ctrl  <= in_ctrl;
            end
        end else if (!r_skid_valid) begin
            if (w_in_fire && w_out_fire) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
                r_skid_ctrl  <= in_ctrl;
            end else if (w_out_fire) begin
                r_main_valid <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_main_data  <= r_skid_data;
            r_main_ctrl  <= r_skid_ctrl;
            r_skid_valid <= 1'b0;
        end
    end

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
    assign occupancy = r_skid_valid ? OCC_FULL : (r_main_valid ? OCC_ONE : OCC_EMPTY);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (r_main_valid & ~out_ready),
        .count   (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (~r_main_valid & out_ready),
        .count   (bubble_count)
    );

endmodule
`default_nettype wire
